rom_port_arbiter: RTL and testbench

//  Shares the single toggle-handshake DDRAM ROM port between two requesters: the ROM loader

---
 rtl/rom_port_arbiter_if.sv | 45 ++++
 rtl/rom_port_arbiter.sv | 134 +++++++++++++
 tb/tb_rom_port_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_port_arbiter_if.sv
// Bundle of the loader write channel, console read channel and shared DDRAM ROM port
// seen by rom_port_arbiter. All handshakes are toggle style: req != ack means pending.
interface rom_port_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);
    logic              LOADING;

    logic              WR_REQ;
    logic              WR_ACK;
    logic [ADDR_W-1:0] WR_ADDR;
    logic [DATA_W-1:0] WR_DATA;

    logic              RD_REQ;
    logic              RD_ACK;
    logic [ADDR_W-1:0] RD_ADDR;
    logic [DATA_W-1:0] RD_DATA;

    logic              MEM_REQ;
    logic              MEM_ACK;
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_DIN;
    logic [DATA_W-1:0] MEM_DOUT;

    // Arbiter view.
    modport slave (
        input  LOADING,
        input  WR_REQ, WR_ADDR, WR_DATA,
        input  RD_REQ, RD_ADDR,
        input  MEM_ACK, MEM_DOUT,
        output WR_ACK, RD_ACK, RD_DATA,
        output MEM_REQ, MEM_WE, MEM_ADDR, MEM_DIN
    );

    // Requesters plus memory, as seen from outside the arbiter.
    modport master (
        output LOADING,
        output WR_REQ, WR_ADDR, WR_DATA,
        output RD_REQ, RD_ADDR,
        output MEM_ACK, MEM_DOUT,
        input  WR_ACK, RD_ACK, RD_DATA,
        input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_DIN
    );
endinterface

// File: rtl/rom_port_arbiter.sv
// Shares the single toggle-handshake DDRAM ROM port between the loader write channel and
// the console read channel, with a starvation limit on the priority side.
module rom_port_arbiter #(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic                 MCLK,
    input  logic                 RESET_N,
    rom_port_arbiter_if.slave    bus
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_WAIT
    } state_e;

    state_e            state_q,    state_d;
    logic              wr_ack_q,   wr_ack_d;
    logic              rd_ack_q,   rd_ack_d;
    logic [DATA_W-1:0] rd_data_q,  rd_data_d;
    logic              mem_req_q,  mem_req_d;
    logic              mem_we_q,   mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q,  mem_din_d;
    logic [CNT_W-1:0]  starve_q,   starve_d;

    logic wr_p, rd_p, prio_p, other_p;
    logic starved, grant_prio, grant_other, pick_wr;

    assign wr_p = bus.WR_REQ ^ wr_ack_q;
    assign rd_p = bus.RD_REQ ^ rd_ack_q;

    // LOADING selects the priority side; it only matters in IDLE, where a grant is made.
    assign prio_p      = bus.LOADING ? wr_p : rd_p;
    assign other_p     = bus.LOADING ? rd_p : wr_p;
    assign starved     = (starve_q == CNT_W'(STARVE_MAX)) && other_p;
    assign grant_prio  = prio_p && !starved;
    assign grant_other = other_p && !grant_prio;
    assign pick_wr     = bus.LOADING ? grant_prio : grant_other;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values; combinational logic below uses blocking assignments.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_INIT;
            wr_ack_q   <= 1'b0;
            rd_ack_q   <= 1'b0;
            rd_data_q  <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            wr_ack_q   <= wr_ack_d;
            rd_ack_q   <= rd_ack_d;
            rd_data_q  <= rd_data_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            starve_q   <= starve_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets its hold value first, so no path can infer a latch.
        state_d    = state_q;
        wr_ack_d   = wr_ack_q;
        rd_ack_d   = rd_ack_q;
        rd_data_d  = rd_data_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        starve_d   = starve_q;

        unique case (state_q)
            ST_INIT: begin
                // Adopt the memory's phase so a late ack from before reset is not
                // mistaken for a completion.
                mem_req_d = bus.MEM_ACK;
                state_d   = ST_IDLE;
            end

            ST_IDLE: begin
                if (!other_p || grant_other) begin
                    starve_d = '0;
                end else if (grant_prio) begin
                    // Cannot overflow: at STARVE_MAX with the other side pending, it wins.
                    starve_d = starve_q + CNT_W'(1);
                end

                if (wr_p || rd_p) begin
                    mem_we_d   = pick_wr;
                    mem_addr_d = pick_wr ? bus.WR_ADDR : bus.RD_ADDR;
                    if (pick_wr) begin
                        mem_din_d = bus.WR_DATA;
                    end
                    mem_req_d  = ~mem_req_q;
                    state_d    = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (bus.MEM_ACK == mem_req_q) begin
                    if (mem_we_q) begin
                        wr_ack_d = bus.WR_REQ;
                    end else begin
                        rd_data_d = bus.MEM_DOUT;
                        rd_ack_d  = bus.RD_REQ;
                    end
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_INIT;
        endcase
    end

    assign bus.WR_ACK   = wr_ack_q;
    assign bus.RD_ACK   = rd_ack_q;
    assign bus.RD_DATA  = rd_data_q;
    assign bus.MEM_REQ  = mem_req_q;
    assign bus.MEM_WE   = mem_we_q;
    assign bus.MEM_ADDR = mem_addr_q;
    assign bus.MEM_DIN  = mem_din_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard bench for rom_port_arbiter: directed stimulus pushes expected memory
// transactions and read data; independent monitors pop and compare.
`timescale 1ns/1ps
module tb_rom_port_arbiter;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 16;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
    } mem_txn_t;

    logic MCLK    = 1'b0;
    logic RESET_N = 1'b0;

    rom_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    rom_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
        .MCLK    (MCLK),
        .RESET_N (RESET_N),
        .bus     (bus.slave)
    );

    always #5 MCLK = ~MCLK;

    int n_checks = 0;
    int n_err    = 0;

    mem_txn_t          exp_mem_q[$];
    logic [DATA_W-1:0] exp_rd_q[$];

    // Memory model state; MEM_ACK starts high so INIT has a phase to adopt.
    logic              m_ack  = 1'b1;
    logic [DATA_W-1:0] m_dout = '0;
    logic              m_busy = 1'b0;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_din;
    int                m_cnt  = 0;
    int                m_lat  = 5;
    bit                m_rand = 1'b0;
    int                n_mem_wr = 0;
    logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];

    logic rd_prev  = 1'b0;
    logic wr_prev  = 1'b0;
    int   n_wr_ack = 0;

    // Auto requesters: re-toggle in the same cycle the previous ack arrives.
    int                rd_auto_n = 0;
    logic [ADDR_W-1:0] rd_auto_addr;
    int                wr_auto_n = 0;
    logic [ADDR_W-1:0] wr_auto_addr;

    assign bus.MEM_ACK  = m_ack;
    assign bus.MEM_DOUT = m_dout;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Memory model + transaction scoreboard + address/data stability monitor.
    always @(posedge MCLK) begin
        #2;
        if (m_busy) begin
            if (RESET_N) begin
                check("mem_we_stable", bus.MEM_WE, m_we);
                check("mem_addr_stable", bus.MEM_ADDR, m_addr);
                if (m_we) check("mem_din_stable", bus.MEM_DIN, m_din);
            end
            if (m_cnt <= 1) begin
                if (m_we) mem[m_addr] = m_din;
                else      m_dout = mem.exists(m_addr) ? mem[m_addr] : '0;
                m_ack  = ~m_ack;
                m_busy = 1'b0;
            end else begin
                m_cnt--;
            end
        end else if (RESET_N && bus.MEM_REQ !== m_ack) begin
            m_busy = 1'b1;
            m_we   = bus.MEM_WE;
            m_addr = bus.MEM_ADDR;
            m_din  = bus.MEM_DIN;
            m_cnt  = m_rand ? int'($urandom_range(20, 1)) : m_lat;
            if (m_we) n_mem_wr++;
            if (exp_mem_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL mem_unexpected: got we=%0b addr=%0h, expected no transaction",
                         m_we, m_addr);
            end else begin
                mem_txn_t e;
                e = exp_mem_q.pop_front();
                check("mem_we", m_we, e.we);
                check("mem_addr", m_addr, e.addr);
                if (e.we) check("mem_din", m_din, e.din);
            end
        end
    end

    // Requester-side monitor: every RD_ACK change must deliver the next expected word.
    always @(posedge MCLK) begin
        #2;
        if (!RESET_N) begin
            rd_prev = bus.RD_ACK;
            wr_prev = bus.WR_ACK;
        end else begin
            if (bus.RD_ACK !== rd_prev) begin
                rd_prev = bus.RD_ACK;
                if (exp_rd_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL rd_unexpected: got RD_ACK change data=%0h, expected none",
                             bus.RD_DATA);
                end else begin
                    check("rd_data", bus.RD_DATA, exp_rd_q.pop_front());
                end
            end
            if (bus.WR_ACK !== wr_prev) begin
                wr_prev = bus.WR_ACK;
                n_wr_ack++;
            end
        end
    end

    task automatic step();
        @(negedge MCLK);
        if (RESET_N) begin
            if (rd_auto_n > 0 && bus.RD_REQ == bus.RD_ACK) begin
                bus.RD_ADDR  = rd_auto_addr;
                bus.RD_REQ   = ~bus.RD_REQ;
                rd_auto_addr = rd_auto_addr + 1'b1;
                rd_auto_n--;
            end
            if (wr_auto_n > 0 && bus.WR_REQ == bus.WR_ACK) begin
                bus.WR_ADDR  = wr_auto_addr;
                bus.WR_DATA  = wr_auto_addr[DATA_W-1:0] ^ 16'hA5A5;
                bus.WR_REQ   = ~bus.WR_REQ;
                wr_auto_addr = wr_auto_addr + 1'b1;
                wr_auto_n--;
            end
        end
    endtask

    task automatic wait_quiet(input string name, input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            done = (bus.WR_REQ == bus.WR_ACK) && (bus.RD_REQ == bus.RD_ACK) &&
                   rd_auto_n == 0 && wr_auto_n == 0 && !m_busy &&
                   exp_mem_q.size() == 0 && exp_rd_q.size() == 0;
        end
        check(name, done, 1'b1);
    endtask

    task automatic wait_busy(input string name, input int budget);
        for (int i = 0; i < budget && !m_busy; i++) step();
        check(name, m_busy, 1'b1);
    endtask

    task automatic push_mem(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        mem_txn_t t;
        t.we = we; t.addr = a; t.din = d;
        exp_mem_q.push_back(t);
    endtask

    initial begin
        int wr_base, mw_base;
        bus.LOADING = 1'b0;
        bus.WR_REQ  = 1'b0; bus.WR_ADDR = '0; bus.WR_DATA = '0;
        bus.RD_REQ  = 1'b0; bus.RD_ADDR = '0;

        // Reset state.
        repeat (3) step();
        check("rst_wr_ack", bus.WR_ACK, 1'b0);
        check("rst_rd_ack", bus.RD_ACK, 1'b0);
        check("rst_rd_data", bus.RD_DATA, 16'h0);
        check("rst_mem_req", bus.MEM_REQ, 1'b0);
        check("rst_mem_we", bus.MEM_WE, 1'b0);
        check("rst_mem_addr", bus.MEM_ADDR, 24'h0);
        check("rst_mem_din", bus.MEM_DIN, 16'h0);
        RESET_N = 1'b1;
        step();
        check("init_adopts_ack", bus.MEM_REQ, 1'b1);

        // 1: single read.
        mem[24'h000100] = 16'hBEEF;
        m_lat = 5;
        push_mem(1'b0, 24'h000100, '0);
        exp_rd_q.push_back(16'hBEEF);
        bus.RD_ADDR = 24'h000100;
        bus.RD_REQ  = 1'b1;
        wait_quiet("t1_done", 100);
        check("t1_rd_ack", bus.RD_ACK, 1'b1);
        check("t1_wr_ack", bus.WR_ACK, 1'b0);
        check("t1_rd_data", bus.RD_DATA, 16'hBEEF);

        // 2: LOADING, simultaneous requests -> write first.
        bus.LOADING = 1'b1;
        m_lat = 3;
        mem[24'h040010] = 16'h7777;
        push_mem(1'b1, 24'h040000, 16'h5A5A);
        push_mem(1'b0, 24'h040010, '0);
        exp_rd_q.push_back(16'h7777);
        bus.WR_ADDR = 24'h040000; bus.WR_DATA = 16'h5A5A; bus.WR_REQ = ~bus.WR_REQ;
        bus.RD_ADDR = 24'h040010; bus.RD_REQ = ~bus.RD_REQ;
        wait_quiet("t2_done", 100);
        check("t2_wr_ack", bus.WR_ACK, 1'b1);
        check("t2_rd_ack", bus.RD_ACK, 1'b0);
        check("t2_mem", mem[24'h040000], 16'h5A5A);

        // 3: reads have priority, write starved for exactly 4 grants.
        bus.LOADING = 1'b0;
        m_lat = 2;
        for (int i = 0; i < 6; i++) mem[24'h010000 + i] = 16'hC000 | 16'(i);
        for (int i = 0; i < 4; i++) push_mem(1'b0, 24'h010000 + i, '0);
        push_mem(1'b1, 24'h020000, 16'h1234);
        push_mem(1'b0, 24'h010004, '0);
        push_mem(1'b0, 24'h010005, '0);
        for (int i = 0; i < 6; i++) exp_rd_q.push_back(16'hC000 | 16'(i));
        bus.WR_ADDR = 24'h020000; bus.WR_DATA = 16'h1234; bus.WR_REQ = ~bus.WR_REQ;
        bus.RD_ADDR = 24'h010000; bus.RD_REQ = ~bus.RD_REQ;
        rd_auto_addr = 24'h010001;
        rd_auto_n    = 5;
        wait_quiet("t3_done", 200);
        check("t3_mem", mem[24'h020000], 16'h1234);

        // 4: reset in WAIT, memory acks during reset.
        m_lat = 10;
        push_mem(1'b0, 24'h030000, '0);
        bus.RD_ADDR = 24'h030000; bus.RD_REQ = ~bus.RD_REQ;
        wait_busy("t4_busy", 20);
        repeat (2) step();
        RESET_N = 1'b0;
        bus.RD_REQ = 1'b0;
        bus.WR_REQ = 1'b0;
        repeat (15) step();
        check("t4_rst_rd_ack", bus.RD_ACK, 1'b0);
        check("t4_rst_wr_ack", bus.WR_ACK, 1'b0);
        RESET_N = 1'b1;
        step();
        check("t4_init_sync", bus.MEM_REQ, m_ack);
        repeat (5) step();
        check("t4_no_rd_ack", bus.RD_ACK, 1'b0);
        check("t4_no_wr_ack", bus.WR_ACK, 1'b0);
        mem[24'h030001] = 16'h4444;
        m_lat = 3;
        push_mem(1'b0, 24'h030001, '0);
        exp_rd_q.push_back(16'h4444);
        bus.RD_ADDR = 24'h030001; bus.RD_REQ = 1'b1;
        wait_quiet("t4_done", 100);
        check("t4_rd_ack", bus.RD_ACK, 1'b1);

        // 5: loader stream with random memory latency.
        bus.LOADING = 1'b1;
        m_rand  = 1'b1;
        wr_base = n_wr_ack;
        mw_base = n_mem_wr;
        for (int i = 0; i < 1024; i++) begin
            logic [ADDR_W-1:0] a;
            a = ADDR_W'(i);
            push_mem(1'b1, a, a[DATA_W-1:0] ^ 16'hA5A5);
        end
        wr_auto_addr = '0;
        wr_auto_n    = 1024;
        wait_quiet("t5_done", 40000);
        m_rand = 1'b0;
        check("t5_wr_acks", n_wr_ack - wr_base, 1024);
        check("t5_mem_writes", n_mem_wr - mw_base, 1024);
        for (int i = 0; i < 1024; i++) begin
            logic [ADDR_W-1:0] a;
            a = ADDR_W'(i);
            check("t5_mem_data", mem.exists(a) ? mem[a] : 16'h0, a[DATA_W-1:0] ^ 16'hA5A5);
        end

        // 6: LOADING drops during a write's WAIT; read wins the next IDLE.
        bus.LOADING = 1'b1;
        m_lat = 6;
        mem[24'h050010] = 16'h8888;
        push_mem(1'b1, 24'h050000, 16'h6666);
        push_mem(1'b0, 24'h050010, '0);
        push_mem(1'b1, 24'h050001, 16'hA5A4);
        exp_rd_q.push_back(16'h8888);
        bus.WR_ADDR = 24'h050000; bus.WR_DATA = 16'h6666; bus.WR_REQ = ~bus.WR_REQ;
        bus.RD_ADDR = 24'h050010; bus.RD_REQ = ~bus.RD_REQ;
        wait_busy("t6_busy", 20);
        step();
        bus.LOADING  = 1'b0;
        wr_auto_addr = 24'h050001;
        wr_auto_n    = 1;
        wait_quiet("t6_done", 200);
        check("t6_mem0", mem[24'h050000], 16'h6666);
        check("t6_mem1", mem[24'h050001], 16'hA5A4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
